rr_grant_sched_8: RTL and testbench

Eight-requester round-robin scheduler that shares one resource and drives it with a one-hot 8-bit select. Each cycle the grant is either all-zero or exactly one hot bit, matching the 3-to-8 decode of the granted index. The block sits between requesting agents and the shared resource's select lines. It holds a grant until the requester releases it or a hold limit expires, then rotates priority to the next index.

---
 rtl/rr_grant_sched_8.sv | 115 +++++++++++
 tb/tb_rr_grant_sched_8.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_sched_8.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_sched_8
// Purpose  : Eight-requester round-robin scheduler that drives a shared
//            resource with a registered one-hot select. A grant is held
//            until its requester releases it or until the hold limit runs
//            out. Each grant is followed by one dead (all-zero) cycle, and
//            priority then moves to the index after the last winner.
// Ports    : clk           - rising-edge clock
//            rst           - synchronous, active-high reset
//            req[7:0]      - level-sensitive request vector
//            enable        - allows new grants (does not revoke an active one)
//            grant[7:0]    - registered one-hot grant, zero when idle
//            grant_id[2:0] - index of the current or most recent grant
//            grant_valid   - high while grant is non-zero
//            timeout_pulse - one-cycle pulse when the hold limit revokes a grant
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_sched_8 #(
  parameter int MAX_HOLD = 16,  // max consecutive grant cycles, 0 = unlimited
  parameter int CNT_W    = 8    // hold counter width, 2**CNT_W > MAX_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       enable,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout_pulse
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam bit             LIMITED   = (MAX_HOLD != 0);
  // Counter value seen during the final permitted grant cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       r_state;
  logic [2:0]       r_last;
  logic [CNT_W-1:0] r_hold_cnt;

  logic       w_pick_found;
  logic [2:0] w_pick_id;
  logic [2:0] w_scan_idx;
  logic       w_hold_expired;

  // Rotating scan: last+1 has top priority and last itself the lowest.
  // The loop runs from the lowest priority offset down to the highest so the
  // nearest set bit after the pointer is the one that sticks.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_id    = r_last;
    w_scan_idx   = r_last;
    for (int k = 8; k >= 1; k--) begin
      w_scan_idx = r_last + 3'(k);
      if (req[w_scan_idx]) begin
        w_pick_found = 1'b1;
        w_pick_id    = w_scan_idx;
      end
    end
  end

  assign w_hold_expired = LIMITED && (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_last        <= 3'd7;  // makes index 0 the first candidate
      r_hold_cnt    <= '0;
      grant         <= 8'h00;
      grant_id      <= 3'd0;
      grant_valid   <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable && w_pick_found) begin
            r_state     <= GRANT;
            grant       <= 8'(1) << w_pick_id;
            grant_id    <= w_pick_id;
            grant_valid <= 1'b1;
            r_last      <= w_pick_id;
            r_hold_cnt  <= '0;
          end
        end
        GRANT: begin
          // Release is checked first so a simultaneous expiry is silent.
          if (!req[grant_id]) begin
            r_state     <= IDLE;
            grant       <= 8'h00;
            grant_valid <= 1'b0;
          end else if (w_hold_expired) begin
            r_state       <= IDLE;
            grant         <= 8'h00;
            grant_valid   <= 1'b0;
            timeout_pulse <= 1'b1;
          end else if (LIMITED) begin
            // Unlimited mode leaves the counter parked at zero.
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          grant       <= 8'h00;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_sched_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_sched_8
// Purpose  : Self-checking bench for rr_grant_sched_8. Four instances with
//            hold limits 16, 4, 3 and 0 share one stimulus stream. A
//            behavioural model per instance is compared on every negative
//            edge, and directed scenarios add hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_sched_8;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       enable;

  logic [7:0] grant_w [NI];
  logic [2:0] id_w    [NI];
  logic       valid_w [NI];
  logic       pulse_w [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_grant_sched_8 #(.MAX_HOLD(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .req(req), .enable(enable),
    .grant(grant_w[0]), .grant_id(id_w[0]), .grant_valid(valid_w[0]),
    .timeout_pulse(pulse_w[0]));
  rr_grant_sched_8 #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .req(req), .enable(enable),
    .grant(grant_w[1]), .grant_id(id_w[1]), .grant_valid(valid_w[1]),
    .timeout_pulse(pulse_w[1]));
  rr_grant_sched_8 #(.MAX_HOLD(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .req(req), .enable(enable),
    .grant(grant_w[2]), .grant_id(id_w[2]), .grant_valid(valid_w[2]),
    .timeout_pulse(pulse_w[2]));
  rr_grant_sched_8 #(.MAX_HOLD(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .req(req), .enable(enable),
    .grant(grant_w[3]), .grant_id(id_w[3]), .grant_valid(valid_w[3]),
    .timeout_pulse(pulse_w[3]));

  // ---------------- behavioural model ----------------
  int hold_lim [NI] = '{16, 4, 3, 0};
  bit m_busy   [NI] = '{0, 0, 0, 0};
  int m_id     [NI] = '{0, 0, 0, 0};
  int m_last   [NI] = '{7, 7, 7, 7};
  int m_held   [NI] = '{0, 0, 0, 0};  // grant cycles spent so far
  bit m_pulse  [NI] = '{0, 0, 0, 0};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int n);
    int cand;
    if (rst) begin
      m_busy[n] = 0; m_id[n] = 0; m_last[n] = 7; m_held[n] = 0; m_pulse[n] = 0;
    end else if (m_busy[n]) begin
      m_pulse[n] = 0;
      if (!req[m_id[n]]) begin
        m_busy[n] = 0;
      end else if (hold_lim[n] != 0 && m_held[n] == hold_lim[n]) begin
        m_busy[n] = 0;
        m_pulse[n] = 1;
      end else begin
        m_held[n] = m_held[n] + 1;
      end
    end else begin
      m_pulse[n] = 0;
      if (enable && req != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          cand = (m_last[n] + k) % 8;
          if (req[cand] && !m_busy[n]) begin
            m_busy[n] = 1; m_id[n] = cand; m_last[n] = cand; m_held[n] = 1;
          end
        end
      end
    end
  endtask

  // Compare at the negative edge, then advance the model with the inputs
  // that the next rising edge will sample (stimulus only moves just after
  // a rising edge).
  initial begin
    forever begin
      @(negedge clk);
      for (int n = 0; n < NI; n++) begin
        check($sformatf("model grant[%0d]", n), grant_w[n],
              m_busy[n] ? (8'h01 << m_id[n]) : 8'h00);
        check($sformatf("model grant_id[%0d]", n), {5'd0, id_w[n]}, 8'(m_id[n]));
        check($sformatf("model grant_valid[%0d]", n), {7'd0, valid_w[n]}, {7'd0, m_busy[n]});
        check($sformatf("model timeout_pulse[%0d]", n), {7'd0, pulse_w[n]}, {7'd0, m_pulse[n]});
      end
      for (int n = 0; n < NI; n++) model_step(n);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [7:0] exp;
    int r;
    rst = 1'b1; req = 8'hFF; enable = 1'b1;

    // Reset with all requests active.
    tick(); tick();
    check("rst grant", grant_w[0], 8'h00);
    check("rst grant_id", {5'd0, id_w[0]}, 8'h00);
    check("rst grant_valid", {7'd0, valid_w[0]}, 8'h00);
    check("rst timeout_pulse", {7'd0, pulse_w[0]}, 8'h00);
    rst = 1'b0;
    tick();
    check("first grant", grant_w[0], 8'h01);

    // Single requester held for three grant cycles.
    req = 8'h00;
    tick();
    check("release to idle", grant_w[0], 8'h00);
    req = 8'h20;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("single grant", grant_w[0], 8'h20);
      check("single grant_id", {5'd0, id_w[0]}, 8'h05);
    end
    req = 8'h00;
    tick();
    check("single released", grant_w[0], 8'h00);
    check("single valid low", {7'd0, valid_w[0]}, 8'h00);
    check("single id kept", {5'd0, id_w[0]}, 8'h05);
    check("collision no pulse h3", {7'd0, pulse_w[2]}, 8'h00);

    // Round-robin fairness: each winner drops its bit after two cycles.
    rst = 1'b1; tick();
    rst = 1'b0; req = 8'hFF;
    tick();
    for (int g = 0; g <= 8; g++) begin
      exp = 8'h01 << (g % 8);
      check("rr grant c1", grant_w[0], exp);
      tick();
      check("rr grant c2", grant_w[0], exp);
      req = 8'hFF & ~exp;
      tick();
      check("rr dead cycle", grant_w[0], 8'h00);
      req = 8'hFF;
      tick();
    end

    // Timeout with MAX_HOLD=4 and two steady requesters.
    rst = 1'b1; tick();
    rst = 1'b0; req = 8'h09;
    tick();
    for (int rd = 0; rd < 2; rd++) begin
      exp = (rd == 0) ? 8'h01 : 8'h08;
      for (int c = 0; c < 4; c++) begin
        check("h4 hold", grant_w[1], exp);
        check("h4 no pulse", {7'd0, pulse_w[1]}, 8'h00);
        tick();
      end
      check("h4 timeout gap", grant_w[1], 8'h00);
      check("h4 timeout pulse", {7'd0, pulse_w[1]}, 8'h01);
      tick();
    end
    check("h4 wrap back", grant_w[1], 8'h01);
    check("h0 unlimited hold", grant_w[3], 8'h01);

    // Enable gating.
    rst = 1'b1; tick();
    rst = 1'b0; req = 8'h44;
    tick();
    check("en grant 04", grant_w[0], 8'h04);
    enable = 1'b0; req = 8'h40;
    tick();
    check("en released", grant_w[0], 8'h00);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("en held off", grant_w[0], 8'h00);
    end
    enable = 1'b1;
    tick();
    check("en grant 40", grant_w[0], 8'h40);

    // Mid-grant reset.
    rst = 1'b1; req = 8'hFF;
    tick();
    check("midrst grant", grant_w[0], 8'h00);
    check("midrst id", {5'd0, id_w[0]}, 8'h00);
    check("midrst valid", {7'd0, valid_w[0]}, 8'h00);
    rst = 1'b0;
    tick();
    check("midrst restart", grant_w[0], 8'h01);

    // Release in the final permitted cycle with MAX_HOLD=3.
    rst = 1'b1; tick();
    rst = 1'b0; req = 8'h01;
    tick(); tick(); tick();
    check("h3 third cycle", grant_w[2], 8'h01);
    req = 8'h00;
    tick();
    check("h3 collision grant", grant_w[2], 8'h00);
    check("h3 collision pulse", {7'd0, pulse_w[2]}, 8'h00);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r == 7 || r == 8) req = req ^ (8'h01 << $urandom_range(0, 7));
      else if (r == 9) req = 8'($urandom_range(0, 255));
      enable = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
